// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch FIFO. It issues in-order word
// requests and discards responses that were still in flight when a redirect occurred.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   dec_ready,
    output logic                   dec_valid,
    output logic [31:0]            dec_inst,
    output logic [31:0]            dec_pc4,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   redirect_target;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW:0]   in_use;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic [31:0]   inst_buf [DEPTH];
    logic [31:0]   pc4_buf  [DEPTH];

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // Credits cover both buffered entries and requests in flight, so a push never hits a full FIFO.
    assign in_use          = {1'b0, outstanding} + {1'b0, count};
    assign imem_req        = reset & ~redirect & (in_use < CREDITS);
    assign imem_addr       = fetch_pc;
    assign req_fire        = imem_req & imem_ready;
    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rvalid);

    assign push      = imem_rvalid & ~redirect & (drop == '0);
    assign dec_valid = (count != '0);
    assign pop       = dec_valid & dec_ready & ~redirect;
    assign dec_inst  = dec_valid ? inst_buf[rd_ptr] : '0;
    assign dec_pc4   = dec_valid ? pc4_buf[rd_ptr]  : '0;
    assign occupancy = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= PC_RESET;
            resp_pc     <= PC_RESET;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                drop     <= outstanding_nxt;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (imem_rvalid && (drop != '0))
                    drop <= drop - CW'(1);
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_buf[wr_ptr] <= imem_rdata;
            pc4_buf[wr_ptr]  <= resp_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an in-order memory model with epoch-tagged
// requests decides which responses survive, and a queue scoreboard holds the expected FIFO.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_ready = 1'b0;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc4;
    logic [$clog2(DEPTH):0] occupancy;

    fetch_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_inst(dec_inst),
        .dec_pc4(dec_pc4), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc4; } ent_t;

    req_t        pend[$];
    ent_t        fq[$];
    logic [31:0] exp_fetch = PC_RESET;
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = -1;
    int          lat_lo = 1, lat_hi = 1, p_rdy = 100, p_mrdy = 100, p_redir = 0;
    logic        force_redir = 1'b0;
    logic [31:0] force_pc = '0;
    logic        last_dv, last_req;
    logic [31:0] last_pc4, last_inst, last_addr, last_occ;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    task automatic set_knobs(input int lo, input int hi, input int rdy, input int mrdy, input int rd);
        lat_lo = lo; lat_hi = hi; p_rdy = rdy; p_mrdy = mrdy; p_redir = rd;
    endtask

    task automatic step();
        logic        do_redir, exp_req, fire, kept, pop;
        logic [31:0] rp;
        ent_t        ent;
        req_t        r;
        int          due;
        @(negedge clk);
        do_redir    = force_redir || ($urandom_range(99) < p_redir);
        rp          = force_redir ? force_pc : $urandom;
        force_redir = 1'b0;
        redirect    = do_redir;
        redirect_pc = rp;
        dec_ready   = ($urandom_range(99) < p_rdy);
        imem_ready  = ($urandom_range(99) < p_mrdy);
        imem_rvalid = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rdata  = imem_rvalid ? mem_word(pend[0].addr) : $urandom;
        #1;
        last_dv = dec_valid; last_req = imem_req; last_addr = imem_addr;
        last_pc4 = dec_pc4; last_inst = dec_inst; last_occ = 32'(occupancy);

        exp_req = !do_redir && ((pend.size() + fq.size()) < DEPTH);
        check("imem_req", imem_req, exp_req);
        if (exp_req) check("imem_addr", imem_addr, exp_fetch);
        check("occupancy", 32'(occupancy), fq.size());
        check("dec_valid", dec_valid, fq.size() != 0);
        if (fq.size() != 0) begin
            check("dec_inst", dec_inst, fq[0].inst);
            check("dec_pc4", dec_pc4, fq[0].pc4);
        end

        fire = exp_req && imem_ready;
        pop  = !do_redir && (fq.size() != 0) && dec_ready;
        kept = 1'b0;
        if (imem_rvalid) begin
            kept = !do_redir && (pend[0].epoch == epoch);
            ent.inst = mem_word(pend[0].addr);
            ent.pc4  = pend[0].addr + 32'd4;
            void'(pend.pop_front());
        end
        if (pop) void'(fq.pop_front());
        if (kept) fq.push_back(ent);
        if (fire) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.addr = exp_fetch; r.epoch = epoch; r.due = due;
            pend.push_back(r);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (do_redir) begin
            epoch++;
            exp_fetch = {rp[31:2], 2'b00};
            fq.delete();
        end
        cyc++;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        redirect = 1'b0; imem_rvalid = 1'b0; dec_ready = 1'b0; imem_ready = 1'b0;
        #1;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_dec_valid", dec_valid, 1'b0);
        check("rst_dec_inst", dec_inst, 32'h0);
        check("rst_dec_pc4", dec_pc4, 32'h0);
        check("rst_occupancy", 32'(occupancy), 32'h0);
        pend.delete(); fq.delete(); epoch++;
        exp_fetch = PC_RESET; cyc = 0; last_due = -1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!last_dv && n < 20) begin step(); n++; end
        check({tag, "_timeout"}, last_dv, 1'b1);
    endtask

    initial begin
        int seen;
        apply_reset();

        // streaming with single-cycle memory
        set_knobs(1, 1, 100, 100, 0);
        step(); check("stream_c0_addr", last_addr, PC_RESET); check("stream_c0_dv", last_dv, 1'b0);
        step(); check("stream_c1_dv", last_dv, 1'b0);
        step(); check("stream_c2_dv", last_dv, 1'b1); check("stream_c2_pc4", last_pc4, PC_RESET + 32'd4);
        check("stream_c2_inst", last_inst, mem_word(PC_RESET));
        seen = 0;
        for (int i = 0; i < 20; i++) begin step(); if (last_dv) seen++; end
        check("stream_rate", seen, 20);

        // backpressure
        set_knobs(1, 1, 0, 100, 0);
        repeat (10) step();
        check("bp_occupancy", last_occ, DEPTH);
        check("bp_req", last_req, 1'b0);
        set_knobs(1, 1, 100, 100, 0);
        repeat (10) step();

        // jump with three responses in flight, redirect coinciding with response and pop
        set_knobs(3, 3, 100, 100, 0);
        repeat (8) step();
        force_redir = 1'b1; force_pc = 32'h50;
        step();
        step(); check("jump_empty", last_dv, 1'b0); check("jump_addr", last_addr, 32'h50);
        wait_valid("jump");
        check("jump_pc4", last_pc4, 32'h54);
        check("jump_inst", last_inst, mem_word(32'h50));

        // unaligned redirect that wraps
        set_knobs(1, 1, 100, 100, 0);
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFE;
        step();
        step(); check("wrap_addr0", last_addr, 32'hFFFF_FFFC);
        step(); check("wrap_addr1", last_addr, 32'h0);
        wait_valid("wrap");
        check("wrap_pc4", last_pc4, 32'h0);

        // randomized traffic with an asynchronous reset mid-burst
        set_knobs(1, 4, 60, 70, 5);
        repeat (700) step();
        set_knobs(1, 3, 90, 90, 3);
        repeat (300) step();
        apply_reset();
        set_knobs(1, 1, 100, 100, 0);
        step(); check("rerst_addr", last_addr, PC_RESET); check("rerst_req", last_req, 1'b1);
        set_knobs(2, 5, 40, 50, 8);
        repeat (700) step();
        set_knobs(1, 2, 20, 100, 2);
        repeat (700) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
